// File: rtl/cache_ram_arbiter.sv
// Shares the single cache-to-RAM port between I-cache refills and D-cache refills/write-backs,
// with a response watchdog. Define CACHE_ARB_RR_EN for round-robin tie-break (default: D over I).
module cache_ram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LINE_W   = 128,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  input  logic              ram_resp,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, SERVE_D, SERVE_I, DONE_D, DONE_I} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [LINE_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              d_done_q, d_done_d;
  logic              i_done_q, i_done_d;
  logic              busy_q, busy_d;
  logic              terr_q, terr_d;
  logic              d_wins_tie_c;
  logic              d_grant_c, i_grant_c;
  logic              wd_hit_c;

  assign d_grant_c = (state_q == IDLE) && d_req && (!i_req || d_wins_tie_c);
  assign i_grant_c = (state_q == IDLE) && i_req && !d_grant_c;
  // Watchdog fires on the cycle whose count increment would reach MAX_WAIT.
  assign wd_hit_c  = (MAX_WAIT != 0) && ((32'(cnt_q) + 32'd1) >= MAX_WAIT);

`ifdef CACHE_ARB_RR_EN
  logic last_i_q, last_i_d;

  assign d_wins_tie_c = last_i_q;

  always_comb begin
    last_i_d = last_i_q;
    if (d_grant_c)      last_i_d = 1'b0;
    else if (i_grant_c) last_i_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_i_q <= 1'b1;
    else     last_i_q <= last_i_d;
  end
`else
  assign d_wins_tie_c = 1'b1;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    terr_d      = terr_q;
    case (state_q)
      IDLE: begin
        if (d_grant_c) begin
          state_d     = SERVE_D;
          ram_en_d    = 1'b1;
          ram_we_d    = d_we;
          ram_addr_d  = d_addr;
          ram_wdata_d = d_wdata;
        end else if (i_grant_c) begin
          state_d     = SERVE_I;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = i_addr;
          ram_wdata_d = '0;
        end
      end
      SERVE_D, SERVE_I: begin
        if (ram_resp) begin
          if (!ram_we_q) rdata_d = ram_rdata;
          ram_en_d = 1'b0;
          state_d  = (state_q == SERVE_D) ? DONE_D : DONE_I;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (wd_hit_c) begin
            ram_en_d = 1'b0;
            terr_d   = 1'b1;
            state_d  = (state_q == SERVE_D) ? DONE_D : DONE_I;
          end
        end
      end
      DONE_D, DONE_I: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_done_d = (state_d == DONE_D);
  assign i_done_d = (state_d == DONE_I);
  assign busy_d   = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
    end
  end

  assign d_done      = d_done_q;
  assign i_done      = i_done_q;
  assign rdata       = rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Bench for cache_ram_arbiter: transaction-level model compared every cycle, plus directed literal checks.
module tb_cache_ram_arbiter;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned MAX_WAIT = 4;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              d_req = 1'b0, d_we = 1'b0, i_req = 1'b0, ram_resp = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0, i_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0, ram_rdata = '0;
  logic              d_done, i_done, ram_en, ram_we, busy, timeout_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [LINE_W-1:0] rdata, ram_wdata;

  cache_ram_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_resp(ram_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction model: who owns the port, how long it has waited, and whether it is finishing.
  int                owner;      // 0 none, 1 D, 2 I
  bit                finishing;
  int                waited;
  bit                last_was_i;
  logic              e_en, e_we, e_dd, e_id, e_busy, e_terr;
  logic [ADDR_W-1:0] e_addr;
  logic [LINE_W-1:0] e_wdata, e_rdata;

  task automatic model_step();
    bool_pick: begin end
    if (rst) begin
      owner = 0; finishing = 0; waited = 0; last_was_i = 1;
      e_en = 0; e_we = 0; e_dd = 0; e_id = 0; e_busy = 0; e_terr = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else if (finishing) begin
      finishing = 0; owner = 0; e_dd = 0; e_id = 0; e_busy = 0;
    end else if (owner == 0) begin
      if (d_req && (!i_req || !RR || last_was_i)) begin
        owner = 1; last_was_i = 0;
        e_en = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_busy = 1; waited = 0;
      end else if (i_req) begin
        owner = 2; last_was_i = 1;
        e_en = 1; e_we = 0; e_addr = i_addr; e_wdata = '0; e_busy = 1; waited = 0;
      end
    end else begin
      bit fin;
      fin = 0;
      if (ram_resp) begin
        if (!e_we) e_rdata = ram_rdata;
        fin = 1;
      end else begin
        waited++;
        if (MAX_WAIT != 0 && waited >= int'(MAX_WAIT)) begin
          e_terr = 1;
          fin = 1;
        end
      end
      if (fin) begin
        e_en = 0; finishing = 1;
        e_dd = (owner == 1); e_id = (owner == 2);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("m_ram_en", ram_en, e_en);
      check("m_ram_we", ram_we, e_we);
      check("m_ram_addr", ram_addr, e_addr);
      check("m_ram_wdata", ram_wdata, e_wdata);
      check("m_rdata", rdata, e_rdata);
      check("m_d_done", d_done, e_dd);
      check("m_i_done", i_done, e_id);
      check("m_busy", busy, e_busy);
      check("m_timeout_err", timeout_err, e_terr);
      check("m_done_excl", d_done & i_done, 1'b0);
    end
  end

  task automatic wait_en();
    for (int k = 0; k < 20; k++) begin
      if (ram_en) return;
      @(negedge clk);
    end
    n_total++;
    $display("FAIL wait_en: got ram_en=%b expected 1 within 20 cycles", ram_en);
  endtask

  task automatic wait_done(output int who);
    who = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_done) begin who = 1; return; end
      if (i_done) begin who = 2; return; end
      @(negedge clk);
    end
    n_total++;
    $display("FAIL wait_done: got no done pulse expected one within 20 cycles");
  endtask

  task automatic serve(input int delay, input logic [LINE_W-1:0] rd);
    repeat (delay) @(negedge clk);
    ram_resp = 1'b1; ram_rdata = rd;
    @(negedge clk);
    ram_resp = 1'b0; ram_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    int who;
    int n_en;
    int order [4];
    logic [LINE_W-1:0] pat_a5;
    pat_a5 = {16{8'hA5}};

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_terr", timeout_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: D refill
    d_req = 1; d_we = 0; d_addr = 32'h100;
    wait_en();
    check("t1_ram_addr", ram_addr, 32'h100);
    check("t1_ram_we", ram_we, 1'b0);
    serve(2, pat_a5);
    wait_done(who);
    check("t1_who", who, 1);
    check("t1_rdata", rdata, pat_a5);
    d_req = 0;
    @(negedge clk);
    check("t1_pulse_len", d_done, 1'b0);

    // 2: D write-back, rdata must hold the earlier refill line
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 128'h1234;
    wait_en();
    check("t2_ram_we", ram_we, 1'b1);
    check("t2_ram_wdata", ram_wdata, 128'h1234);
    serve(1, 128'hDEAD);
    wait_done(who);
    check("t2_who", who, 1);
    check("t2_rdata_kept", rdata, pat_a5);
    d_req = 0; d_we = 0;
    @(negedge clk);

    // 4: watchdog, no response
    d_req = 1; d_addr = 32'h500;
    wait_en();
    n_en = 0;
    while (ram_en && n_en < 20) begin n_en++; @(negedge clk); end
    check("t4_en_cycles", n_en, 4);
    check("t4_d_done", d_done, 1'b1);
    check("t4_terr", timeout_err, 1'b1);
    check("t4_rdata_kept", rdata, pat_a5);
    d_req = 0;
    @(negedge clk);
    i_req = 1; i_addr = 32'h600;
    wait_en();
    serve(1, 128'h6666);
    wait_done(who);
    check("t4_next_who", who, 2);
    check("t4_terr_sticky", timeout_err, 1'b1);
    i_req = 0;
    @(negedge clk);

    // 5: reset during SERVE_I, late response must be ignored
    i_req = 1; i_addr = 32'h700;
    wait_en();
    rst = 1; i_req = 0;
    @(negedge clk);
    rst = 0; ram_resp = 1; ram_rdata = 128'h7777;
    check("t5_ram_en", ram_en, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_terr", timeout_err, 1'b0);
    check("t5_rdata", rdata, '0);
    @(negedge clk);
    ram_resp = 0; ram_rdata = '0;
    check("t5_no_i_done", i_done, 1'b0);
    check("t5_busy_after", busy, 1'b0);

    // 3: three ties right after reset, then a tie where the loser stays requesting
    for (int t = 0; t < 3; t++) begin
      d_req = 1; i_req = 1; d_addr = 32'h300 + 32'(t); i_addr = 32'h400 + 32'(t);
      wait_en();
      serve(0, 128'(t + 1) * 128'h1111);
      wait_done(order[t]);
      d_req = 0; i_req = 0;
      @(negedge clk);
    end
    check("t3_tie0", order[0], 1);
    check("t3_tie1", order[1], RR ? 2 : 1);
    check("t3_tie2", order[2], 1);
    d_req = 1; i_req = 1; d_addr = 32'h380; i_addr = 32'h480;
    wait_en();
    serve(0, 128'hABCD);
    wait_done(who);
    check("t3_first", who, RR ? 2 : 1);
    if (who == 1) d_req = 0; else i_req = 0;
    @(negedge clk);
    check("t3_idle_gap", busy, 1'b0);
    wait_en();
    if (i_req) check("t3_i_we", ram_we, 1'b0);
    serve(1, 128'hBCDE);
    wait_done(who);
    check("t3_second", who, RR ? 1 : 2);
    d_req = 0; i_req = 0;
    @(negedge clk);

    // 6: I drops its request right after the grant
    i_req = 1; i_addr = 32'h800;
    wait_en();
    i_req = 0;
    serve(2, 128'hC0FFEE);
    wait_done(who);
    check("t6_who", who, 2);
    check("t6_rdata", rdata, 128'hC0FFEE);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
